rd_txn_slot: RTL and testbench



---
 rtl/rd_txn_slot.sv | 156 +++++++++++++++
 tb/tb_rd_txn_slot.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_txn_slot.sv
// rd_txn_slot: tracks one outstanding AXI read from AR allocation to the final R beat
module rd_txn_slot #(
  parameter int CntWidth = 10,
  parameter int IdWidth  = 4,
  parameter int LenWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                prescaled_en_i,
  input  logic                clear_i,
  input  logic                alloc_i,
  input  logic [IdWidth-1:0]  alloc_id_i,
  input  logic [LenWidth-1:0] alloc_len_i,
  input  logic                ar_hs_i,
  input  logic                r_sel_i,
  input  logic                r_valid_i,
  input  logic                r_ready_i,
  input  logic                r_last_i,
  input  logic [CntWidth-1:0] budget_ar_i,
  input  logic [CntWidth-1:0] budget_rfirst_i,
  input  logic [CntWidth-1:0] budget_rhs_i,
  input  logic [CntWidth-1:0] budget_burst_i,
  output logic                free_o,
  output logic [1:0]          state_o,
  output logic [IdWidth-1:0]  id_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [2:0]          fault_code_o,
  output logic [CntWidth-1:0] cnt_ar_o,
  output logic [CntWidth-1:0] cnt_rfirst_o,
  output logic [CntWidth-1:0] cnt_rhs_o,
  output logic [CntWidth-1:0] cnt_burst_o
);
  typedef enum logic [1:0] {Free = 2'd0, ReadAddr = 2'd1, ReadData = 2'd2, Fault = 2'd3} state_e;
  state_e state_q, state_d;
  logic [IdWidth-1:0] id_q;
  logic [LenWidth-1:0] len_q;
  logic [LenWidth:0] beats_q, beats_nx;
  logic ar_acc_q, first_hs_q, done_q, to_q;
  logic [2:0] code_q, code_d, to_ra, to_rd;
  logic [CntWidth-1:0] cnt_ar_q, cnt_rfirst_q, cnt_rhs_q, cnt_burst_q;
  logic ev, hs, full, cpl, mis, tick, inc_ar, inc_rf, inc_rh, inc_bu;
  assign ev       = r_sel_i && r_valid_i;
  assign hs       = ev && r_ready_i;
  assign beats_nx = beats_q + (LenWidth+1)'(1);
  assign full     = beats_nx == ({1'b0, len_q} + (LenWidth+1)'(1));
  assign cpl      = hs && r_last_i && full;
  assign mis      = hs && (r_last_i != full);
  assign to_ra    = (budget_ar_i != '0 && cnt_ar_q >= budget_ar_i) ? 3'd1 :
                    (budget_rfirst_i != '0 && cnt_rfirst_q >= budget_rfirst_i) ? 3'd2 : 3'd0;
  assign to_rd    = (budget_rhs_i != '0 && cnt_rhs_q >= budget_rhs_i) ? 3'd3 :
                    (budget_burst_i != '0 && cnt_burst_q >= budget_burst_i) ? 3'd4 : 3'd0;
  // counters only advance on cycles where the transaction stays in flight
  assign tick   = prescaled_en_i && (state_q == ReadAddr || state_q == ReadData) &&
                  (state_d == ReadAddr || state_d == ReadData);
  assign inc_ar = tick && state_q == ReadAddr && !ar_acc_q && !ar_hs_i;
  assign inc_rf = tick && state_q == ReadAddr;
  assign inc_rh = tick && state_q == ReadData && !first_hs_q && !hs;
  assign inc_bu = tick && state_q == ReadData;
  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= Free;
    else         state_q <= state_d;
  end
  // next state and fault code; clear overrides, then completion, protocol fault, timeout
  always_comb begin
    state_d = state_q;
    code_d  = (state_q == Fault) ? code_q : 3'd0;
    case (state_q)
      Free: if (alloc_i) state_d = ReadAddr;
      ReadAddr: begin
        if (ev && !ar_acc_q) begin
          state_d = Fault;
          code_d  = 3'd5;
        end else if (cpl) state_d = Free;
        else if (mis) begin
          state_d = Fault;
          code_d  = 3'd6;
        end else if (to_ra != 3'd0) begin
          state_d = Fault;
          code_d  = to_ra;
        end else if (ev) state_d = ReadData;
      end
      ReadData: begin
        if (cpl) state_d = Free;
        else if (mis) begin
          state_d = Fault;
          code_d  = 3'd6;
        end else if (to_rd != 3'd0) begin
          state_d = Fault;
          code_d  = to_rd;
        end
      end
      default: state_d = Fault;
    endcase
    if (clear_i) begin
      state_d = Free;
      code_d  = 3'd0;
    end
  end
  // transaction context, sticky flags, status and saturating counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni || clear_i) begin
      id_q         <= '0;
      len_q        <= '0;
      beats_q      <= '0;
      ar_acc_q     <= 1'b0;
      first_hs_q   <= 1'b0;
      done_q       <= 1'b0;
      to_q         <= 1'b0;
      code_q       <= 3'd0;
      cnt_ar_q     <= '0;
      cnt_rfirst_q <= '0;
      cnt_rhs_q    <= '0;
      cnt_burst_q  <= '0;
    end else begin
      done_q <= state_q != Free && state_d == Free;
      code_q <= code_d;
      to_q   <= code_d != 3'd0 && code_d < 3'd5;
      if (state_q == Free && alloc_i) begin
        id_q         <= alloc_id_i;
        len_q        <= alloc_len_i;
        beats_q      <= '0;
        ar_acc_q     <= ar_hs_i;
        first_hs_q   <= 1'b0;
        cnt_ar_q     <= '0;
        cnt_rfirst_q <= '0;
        cnt_rhs_q    <= '0;
        cnt_burst_q  <= '0;
      end else begin
        if (state_q == ReadAddr && ar_hs_i) ar_acc_q <= 1'b1;
        if (hs && (state_q == ReadData || (state_q == ReadAddr && ar_acc_q))) begin
          beats_q    <= beats_nx;
          first_hs_q <= 1'b1;
        end
        cnt_ar_q     <= cnt_ar_q + CntWidth'(inc_ar && !(&cnt_ar_q));
        cnt_rfirst_q <= cnt_rfirst_q + CntWidth'(inc_rf && !(&cnt_rfirst_q));
        cnt_rhs_q    <= cnt_rhs_q + CntWidth'(inc_rh && !(&cnt_rhs_q));
        cnt_burst_q  <= cnt_burst_q + CntWidth'(inc_bu && !(&cnt_burst_q));
      end
    end
  end
  // outputs straight from registers
  always_comb begin
    free_o       = state_q == Free;
    state_o      = state_q;
    id_o         = id_q;
    done_o       = done_q;
    timeout_o    = to_q;
    fault_code_o = code_q;
    cnt_ar_o     = cnt_ar_q;
    cnt_rfirst_o = cnt_rfirst_q;
    cnt_rhs_o    = cnt_rhs_q;
    cnt_burst_o  = cnt_burst_q;
  end
endmodule

// File: tb/tb_rd_txn_slot.sv
// tb_rd_txn_slot: random and directed checks of rd_txn_slot against a behavioural model
module tb_rd_txn_slot;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en, clr, alloc, arhs, sel, valid, ready, last;
  logic [3:0] aid;
  logic [7:0] alen;
  logic [9:0] b_ar, b_rf, b_rh, b_bu;
  logic free, done, tout;
  logic [1:0] state;
  logic [3:0] id;
  logic [2:0] code;
  logic [9:0] c_ar, c_rf, c_rh, c_bu;
  int errors = 0;
  int checks = 0;
  int ms, mid, mlen, mbeats, mcode, mdone, macc, mfhs;
  int mc [4];
  bit run = 1'b0;

  always #5 clk = ~clk;

  rd_txn_slot dut (
    .clk_i(clk), .rst_ni(rst_n), .prescaled_en_i(en), .clear_i(clr), .alloc_i(alloc),
    .alloc_id_i(aid), .alloc_len_i(alen), .ar_hs_i(arhs), .r_sel_i(sel), .r_valid_i(valid),
    .r_ready_i(ready), .r_last_i(last), .budget_ar_i(b_ar), .budget_rfirst_i(b_rf),
    .budget_rhs_i(b_rh), .budget_burst_i(b_bu), .free_o(free), .state_o(state), .id_o(id),
    .done_o(done), .timeout_o(tout), .fault_code_o(code), .cnt_ar_o(c_ar),
    .cnt_rfirst_o(c_rf), .cnt_rhs_o(c_rh), .cnt_burst_o(c_bu)
  );

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", n, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= 1023) ? 1023 : v + 1;
  endfunction

  // reference model: one transaction's life expressed as phase, beat count and four timers
  always @(posedge clk or negedge rst_n) begin
    int bud [4];
    int expired, after;
    bit ev, hs;
    if (!rst_n || clr) begin
      ms = 0; mid = 0; mlen = 0; mbeats = 0; mcode = 0; mdone = 0; macc = 0; mfhs = 0;
      mc = '{0, 0, 0, 0};
    end else begin
      mdone = 0;
      if (ms == 0) begin
        if (alloc) begin
          ms = 1; mid = aid; mlen = alen; mbeats = 0; macc = arhs; mfhs = 0;
          mc = '{0, 0, 0, 0};
        end
      end else if (ms != 3) begin
        ev = sel && valid;
        hs = ev && ready;
        bud = '{b_ar, b_rf, b_rh, b_bu};
        expired = 0;
        for (int k = (ms == 1 ? 0 : 2); k < (ms == 1 ? 2 : 4); k++)
          if (expired == 0 && bud[k] != 0 && mc[k] >= bud[k]) expired = k + 1;
        after = mbeats + (hs ? 1 : 0);
        if (ms == 1 && ev && !macc) begin
          ms = 3; mcode = 5;
        end else if (hs && last && after == mlen + 1) begin
          ms = 0; mdone = 1;
        end else if (hs && (last || after == mlen + 1)) begin
          ms = 3; mcode = 6;
        end else if (expired != 0) begin
          ms = 3; mcode = expired;
        end else begin
          if (en) begin
            if (ms == 1 && !macc && !arhs) mc[0] = sat(mc[0]);
            if (ms == 1) mc[1] = sat(mc[1]);
            if (ms == 2 && !mfhs && !hs) mc[2] = sat(mc[2]);
            if (ms == 2) mc[3] = sat(mc[3]);
          end
          if (ms == 1 && arhs) macc = 1;
          if (hs) begin
            mbeats = after;
            mfhs = 1;
          end
          if (ev) ms = 2;
        end
      end
    end
  end

  // compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (rst_n && run) begin
      chk("state", state, ms);
      chk("free", free, ms == 0);
      chk("id", id, mid);
      chk("done", done, mdone);
      chk("code", code, ms == 3 ? mcode : 0);
      chk("timeout", tout, ms == 3 && mcode >= 1 && mcode <= 4);
      chk("cnt_ar", c_ar, mc[0]);
      chk("cnt_rfirst", c_rf, mc[1]);
      chk("cnt_rhs", c_rh, mc[2]);
      chk("cnt_burst", c_bu, mc[3]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; clr = 1'b0; alloc = 1'b0; arhs = 1'b0; sel = 1'b0; valid = 1'b0;
    ready = 1'b0; last = 1'b0; aid = 4'd0; alen = 8'd0;
  endtask

  task automatic start(input logic [3:0] i, input logic [7:0] l, input logic h);
    alloc = 1'b1; aid = i; alen = l; arhs = h;
    step();
    alloc = 1'b0; arhs = 1'b0;
  endtask

  task automatic beat(input logic l);
    sel = 1'b1; valid = 1'b1; ready = 1'b1; last = l;
    step();
    sel = 1'b0; valid = 1'b0; ready = 1'b0; last = 1'b0;
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    bit hit;
    idle();
    b_ar = 0; b_rf = 0; b_rh = 0; b_bu = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run = 1'b1;
    chk("rst_free", free, 1);
    chk("rst_state", state, 0);
    chk("rst_cnt_burst", c_bu, 0);
    // AR budget expiry
    b_ar = 4;
    start(4'd3, 8'd0, 1'b0);
    repeat (4) step();
    chk("ar_cnt_at4", c_ar, 4);
    chk("ar_state_at4", state, 1);
    step();
    chk("ar_to_state", state, 3);
    chk("ar_to_code", code, 1);
    chk("ar_to_flag", tout, 1);
    chk("ar_cnt_held", c_ar, 4);
    do_clear();
    chk("clr_state", state, 0);
    chk("clr_cnt_ar", c_ar, 0);
    b_ar = 0;
    // clean four-beat burst
    start(4'd5, 8'd3, 1'b1);
    beat(1'b0); beat(1'b0); beat(1'b0); beat(1'b1);
    chk("cpl_state", state, 0);
    chk("cpl_done", done, 1);
    chk("cpl_cnt_rhs", c_rh, 0);
    chk("cpl_cnt_burst", c_bu, 2);
    chk("cpl_cnt_rfirst", c_rf, 1);
    chk("cpl_id", id, 5);
    step();
    chk("cpl_done_pulse", done, 0);
    // early last
    start(4'd1, 8'd3, 1'b1);
    beat(1'b0); beat(1'b0); beat(1'b1);
    chk("early_last_code", code, 6);
    chk("early_last_to", tout, 0);
    do_clear();
    // missing last
    start(4'd2, 8'd3, 1'b1);
    beat(1'b0); beat(1'b0); beat(1'b0); beat(1'b0);
    chk("no_last_code", code, 6);
    do_clear();
    // R before AR accepted
    start(4'd6, 8'd0, 1'b0);
    sel = 1'b1; valid = 1'b1;
    step();
    sel = 1'b0; valid = 1'b0;
    chk("early_r_code", code, 5);
    chk("early_r_to", tout, 0);
    do_clear();
    // completion wins over a burst budget reached in the same cycle
    b_bu = 2;
    start(4'd7, 8'd1, 1'b1);
    beat(1'b0);
    step(); step();
    chk("race_cnt_burst", c_bu, 2);
    beat(1'b1);
    chk("race_done", done, 1);
    chk("race_state", state, 0);
    chk("race_code", code, 0);
    // long burst at the largest budget, half-rate prescaler
    b_bu = 1023;
    start(4'd8, 8'd255, 1'b1);
    beat(1'b0);
    hit = 1'b0;
    for (int i = 0; i < 2200 && !hit; i++) begin
      en = i[0];
      step();
      hit = state == 2'd3;
    end
    en = 1'b1;
    chk("long_reached_fault", hit, 1);
    chk("long_code", code, 4);
    chk("long_to", tout, 1);
    chk("long_cnt_burst", c_bu, 1023);
    do_clear();
    // saturation with the burst check disabled, then clear mid-burst
    b_bu = 0;
    start(4'd9, 8'd255, 1'b1);
    beat(1'b0);
    for (int i = 0; i < 2200; i++) begin
      en = i[0];
      step();
    end
    en = 1'b1;
    chk("sat_cnt_burst", c_bu, 1023);
    chk("sat_state", state, 2);
    do_clear();
    chk("mid_clr_state", state, 0);
    chk("mid_clr_cnt_burst", c_bu, 0);
    chk("mid_clr_cnt_rfirst", c_rf, 0);
    // alloc dropped when clear coincides
    alloc = 1'b1; clr = 1'b1;
    step();
    alloc = 1'b0; clr = 1'b0;
    chk("alloc_clr_free", free, 1);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        b_ar = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(1, 12));
        b_rf = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(1, 20));
        b_rh = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(1, 12));
        b_bu = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(1, 25));
      end
      en = 1'($urandom_range(0, 1));
      clr = $urandom_range(0, 59) == 0;
      alloc = $urandom_range(0, 3) == 0;
      aid = 4'($urandom);
      alen = 8'($urandom_range(0, 3));
      arhs = $urandom_range(0, 2) == 0;
      sel = 1'($urandom_range(0, 1));
      valid = 1'($urandom_range(0, 1));
      ready = 1'($urandom_range(0, 1));
      last = $urandom_range(0, 2) == 0;
      step();
    end
    idle();
    step(); step();
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
